// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter that grants one of N_REQ requesters access to a
// single SPI master. It launches the transfer, supervises completion with a
// timeout and enforces an idle gap between transactions.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   req             per-requester request level (held until ack)
//   req_len         5-bit transfer length per requester (slice i = [5i+4:5i])
//   req_mode        SPI mode bit per requester
//   req_tx          32-bit transmit word per requester (slice i = [32i+31:32i])
//   ack             one-hot 1-cycle pulse: request captured
//   done            one-hot 1-cycle pulse: transaction finished
//   err             qualifies done: timeout or zero-length request
//   rx_data         received word, updated on successful done
//   spi_act         1-cycle start pulse to the SPI master
//   spi_len/mode/tx transfer descriptor to the SPI master
//   spi_busy        SPI master busy, blocks new grants
//   spi_valid       SPI master completion pulse, spi_rx valid with it
//   spi_rx          SPI master receive word
module spi_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP     = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [5*N_REQ-1:0]   req_len,
  input  logic [N_REQ-1:0]     req_mode,
  input  logic [32*N_REQ-1:0]  req_tx,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [31:0]          rx_data,
  output logic                 spi_act,
  output logic [4:0]           spi_len,
  output logic                 spi_mode,
  output logic [31:0]          spi_tx,
  input  logic                 spi_busy,
  input  logic                 spi_valid,
  input  logic [31:0]          spi_rx
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_XFER, ST_GAP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  int                   rr_dist, rr_best;
  logic [N_REQ-1:0]     pick_oh, last_oh;
  logic [4:0]           sel_len;
  logic                 sel_mode;
  logic [31:0]          sel_tx;
  logic [N_REQ-1:0]     ack_nxt, done_nxt;
  logic                 err_nxt, act_nxt, grant, rx_load;

  // Round-robin search: smallest distance from last_grant+1 wins.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    rr_best = int'(N_REQ);
    rr_dist = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      rr_dist = (i + int'(N_REQ) - int'(last_grant) - 1) % int'(N_REQ);
      if (req[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        pick    = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Descriptor of the candidate requester.
  always_comb begin
    sel_len  = '0;
    sel_mode = 1'b0;
    sel_tx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick == IDX_W'(i)) begin
        sel_len  = req_len[5*i +: 5];
        sel_mode = req_mode[i];
        sel_tx   = req_tx[32*i +: 32];
      end
    end
  end

  always_comb begin
    pick_oh             = '0;
    pick_oh[pick]       = 1'b1;
    last_oh             = '0;
    last_oh[last_grant] = 1'b1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    act_nxt   = 1'b0;
    grant     = 1'b0;
    rx_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found && !spi_busy) begin
          grant     = 1'b1;
          ack_nxt   = pick_oh;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_nxt = '0;
        // Zero-length requests are rejected without touching the SPI master.
        if (spi_len == 5'd0) begin
          done_nxt  = last_oh;
          err_nxt   = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          act_nxt   = 1'b1;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        // Completion on the final counted cycle still wins over the timeout.
        if (spi_valid) begin
          done_nxt  = last_oh;
          rx_load   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end else if (cnt == TO_LAST) begin
          done_nxt  = last_oh;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      ack        <= '0;
      done       <= '0;
      err        <= 1'b0;
      spi_act    <= 1'b0;
      spi_len    <= '0;
      spi_mode   <= 1'b0;
      spi_tx     <= '0;
      rx_data    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ack     <= ack_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      spi_act <= act_nxt;
      if (grant) begin
        last_grant <= pick;
        spi_len    <= sel_len;
        spi_mode   <= sel_mode;
        spi_tx     <= sel_tx;
      end
      if (rx_load) begin
        rx_data <= spi_rx;
      end
    end
  end

endmodule
